// File: rtl/tate_pairing_seq.sv
// Sequencer for an external Duursma-Lee engine and a final-exponentiation engine; streams the result.
// Optional per-stage timeout enabled by defining TATE_SEQ_TIMEOUT_EN.
module tate_pairing_seq #(
   parameter int OP_W    = 194,
   parameter int RES_W   = 6 * OP_W,
   parameter int OUT_W   = 150,
   parameter int RST_CYC = 2,
   parameter int TMO_CYC = 65535,
   localparam int NWORDS = (RES_W + OUT_W - 1) / OUT_W,
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   input  logic [OP_W-1:0]  x1,
   input  logic [OP_W-1:0]  y1,
   input  logic [OP_W-1:0]  x2,
   input  logic [OP_W-1:0]  y2,
   output logic             s1_rst,
   output logic [OP_W-1:0]  s1_x1,
   output logic [OP_W-1:0]  s1_y1,
   output logic [OP_W-1:0]  s1_x2,
   output logic [OP_W-1:0]  s1_y2,
   input  logic             s1_done,
   input  logic [RES_W-1:0] s1_res,
   output logic             s2_rst,
   output logic [RES_W-1:0] s2_in,
   input  logic             s2_done,
   input  logic [RES_W-1:0] s2_res,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [OUT_W-1:0] o_data,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_last,
   output logic             err
);

   localparam int PAD_W = NWORDS * OUT_W;
   localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST1   = 3'd1,
      S_RUN1   = 3'd2,
      S_RST2   = 3'd3,
      S_RUN2   = 3'd4,
      S_STREAM = 3'd5
   } state_t;

   state_t            state_r, state_nx_s;
   logic [RC_W-1:0]   rst_cnt_r;
   logic              s1_done_q_r, s2_done_q_r;
   logic              s1_edge_s, s2_edge_s, rst_done_s, accept_s, tmo_hit_s;
   logic              ready_r, s1_rst_r, s2_rst_r, o_valid_r, o_last_r;
   logic [IDX_W-1:0]  o_idx_r, idx_nx_s;
   logic [OP_W-1:0]   x1_r, y1_r, x2_r, y2_r;
   logic [RES_W-1:0]  s2_in_r;
   logic [PAD_W-1:0]  res_buf_r;

   // Only a 0->1 transition of done counts; a level left high from before the run is ignored.
   assign s1_edge_s  = s1_done & ~s1_done_q_r;
   assign s2_edge_s  = s2_done & ~s2_done_q_r;
   assign rst_done_s = (rst_cnt_r == RC_W'(RST_CYC - 1));
   assign accept_s   = start & ready_r;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and next stream index.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = o_idx_r;
      if (o_valid_r && o_ready) begin
         if (o_last_r) begin
            idx_nx_s = {IDX_W{1'b0}};
         end else begin
            idx_nx_s = o_idx_r + IDX_W'(1);
         end
      end else begin
         idx_nx_s = o_idx_r;
      end
      case (state_r)
         S_IDLE:   if (accept_s) state_nx_s = S_RST1; else state_nx_s = S_IDLE;
         S_RST1:   if (rst_done_s) state_nx_s = S_RUN1; else state_nx_s = S_RST1;
         S_RUN1: begin
            if (s1_edge_s) begin
               state_nx_s = S_RST2;
            end else if (tmo_hit_s) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_RUN1;
            end
         end
         S_RST2:   if (rst_done_s) state_nx_s = S_RUN2; else state_nx_s = S_RST2;
         S_RUN2: begin
            if (s2_edge_s) begin
               state_nx_s = S_STREAM;
            end else if (tmo_hit_s) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_RUN2;
            end
         end
         S_STREAM: begin
            if (o_valid_r && o_ready && o_last_r) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_STREAM;
            end
         end
         default:  state_nx_s = S_IDLE;
      endcase
   end

   // Datapath, counters and registered outputs; the result buffer shifts one word per accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt_r   <= {RC_W{1'b0}};
         s1_done_q_r <= 1'b0;
         s2_done_q_r <= 1'b0;
         ready_r     <= 1'b0;
         s1_rst_r    <= 1'b1;
         s2_rst_r    <= 1'b1;
         o_valid_r   <= 1'b0;
         o_last_r    <= 1'b0;
         o_idx_r     <= {IDX_W{1'b0}};
         x1_r        <= {OP_W{1'b0}};
         y1_r        <= {OP_W{1'b0}};
         x2_r        <= {OP_W{1'b0}};
         y2_r        <= {OP_W{1'b0}};
         s2_in_r     <= {RES_W{1'b0}};
         res_buf_r   <= {PAD_W{1'b0}};
      end else begin
         s1_done_q_r <= s1_done;
         s2_done_q_r <= s2_done;
         if (((state_r == S_RST1) || (state_r == S_RST2)) && (state_nx_s == state_r)) begin
            rst_cnt_r <= rst_cnt_r + RC_W'(1);
         end else begin
            rst_cnt_r <= {RC_W{1'b0}};
         end
         if (accept_s) begin
            x1_r <= x1;
            y1_r <= y1;
            x2_r <= x2;
            y2_r <= y2;
         end
         if ((state_r == S_RUN1) && s1_edge_s) begin
            s2_in_r <= s1_res;
         end
         if ((state_r == S_RUN2) && s2_edge_s) begin
            res_buf_r <= PAD_W'(s2_res);
         end else if (o_valid_r && o_ready) begin
            res_buf_r <= res_buf_r >> OUT_W;
         end
         ready_r   <= (state_nx_s == S_IDLE);
         s1_rst_r  <= (state_nx_s != S_RUN1);
         s2_rst_r  <= (state_nx_s != S_RUN2);
         o_valid_r <= (state_nx_s == S_STREAM);
         o_idx_r   <= idx_nx_s;
         o_last_r  <= (state_nx_s == S_STREAM) && (idx_nx_s == LAST_IDX);
      end
   end

`ifdef TATE_SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             err_r;

   assign tmo_hit_s = ((state_r == S_RUN1) || (state_r == S_RUN2)) &&
                      (tmo_cnt_r == TMO_W'(TMO_CYC - 1));

   // Cycles spent in the current run state; err sticks until reset or the next accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
         err_r     <= 1'b0;
      end else begin
         if (((state_r == S_RUN1) || (state_r == S_RUN2)) && (state_nx_s == state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
         end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
         end
         if (accept_s) begin
            err_r <= 1'b0;
         end else if (tmo_hit_s && (state_nx_s == S_IDLE)) begin
            err_r <= 1'b1;
         end
      end
   end

   assign err = err_r;
`else
   logic unused_tmo_s;
   assign unused_tmo_s = (TMO_CYC > 0);
   assign tmo_hit_s    = 1'b0;
   assign err          = 1'b0;
`endif

   assign ready   = ready_r;
   assign s1_rst  = s1_rst_r;
   assign s2_rst  = s2_rst_r;
   assign s1_x1   = x1_r;
   assign s1_y1   = y1_r;
   assign s1_x2   = x2_r;
   assign s1_y2   = y2_r;
   assign s2_in   = s2_in_r;
   assign o_valid = o_valid_r;
   assign o_data  = res_buf_r[OUT_W-1:0];
   assign o_idx   = o_idx_r;
   assign o_last  = o_last_r;

endmodule
